// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/data bundle between the ALU-side requester and the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] binary;
  logic [15:0]      bcd;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start,
    output binary,
    input  bcd,
    input  busy,
    input  done,
    input  overflow
  );

  modport slave (
    input  start,
    input  binary,
    output bcd,
    output busy,
    output done,
    output overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the seven-segment multiplexer.
// Optional BIN_TO_BCD_SAT_EN: clamp bcd to 16'h9999 when the value exceeds 9999.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  bin_to_bcd_seq_if.slave  conv_io
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [19:0]      scratch_q, scratch_d, scratch_adj;
  logic [4:0]       cnt_q, cnt_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Add-3 adjust on the pre-shift digits, so the shift sees corrected values.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (conv_io.start) begin
          shreg_d   = conv_io.binary;
          scratch_d = '0;
          cnt_d     = 5'(WIDTH);
          state_d   = StShift;
        end
      end
      StShift: begin
        scratch_d = {scratch_adj[18:0], shreg_q[WIDTH-1]};
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        ovf_d = |scratch_q[19:16];
`ifdef BIN_TO_BCD_SAT_EN
        bcd_d = (|scratch_q[19:16]) ? 16'h9999 : scratch_q[15:0];
`else
        bcd_d = scratch_q[15:0];
`endif
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign conv_io.bcd      = bcd_q;
  assign conv_io.busy     = (state_q != StIdle);
  assign conv_io.done     = done_q;
  assign conv_io.overflow = ovf_q;

endmodule
